// File: rtl/recompute_mapper.sv
// recompute_mapper
//   Steers redundant-unit (RU) results onto systolic columns according to a
//   small mapping table. Requests are handled by a three-state FSM: IDLE
//   accepts a request, COMMIT validates it and updates the table, and SETTLE
//   waits while the RU delay line refills for the new mapping.
//
// Parameters
//   COLS       number of systolic columns (>= 2)
//   WORD_SIZE  data word width
//   NUM_RU     number of redundant units
//   RU_SKEW    cycles by which RU results lead systolic results (0..7)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   map_valid/ready     request handshake
//   map_ru_idx          RU being remapped
//   map_col             target column
//   map_en              1 = enable RU on map_col, 0 = release RU
//   map_err             one-cycle pulse when a request is rejected
//   systolic_bottom_in  column results, column c at [c*WORD_SIZE +: WORD_SIZE]
//   ru_bottom_in        RU results, RU i at [i*WORD_SIZE +: WORD_SIZE]
//   bottom_out          registered repaired column results
//   out_valid           bottom_out was produced from a settled mapping
//
// Optional feature (macro RU_MAP_STATUS_EN)
//   col_remapped        per-column "served by an RU" flags, aligned with bottom_out
//   commit_count        saturating count of accepted requests
module recompute_mapper #(
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int NUM_RU    = 4,
  parameter int RU_SKEW   = 2,
  localparam int NUM_BITS_COLS = $clog2(COLS),
  localparam int RU_IDX_W      = (NUM_RU > 1) ? $clog2(NUM_RU) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          map_valid,
  output logic                          map_ready,
  input  logic [RU_IDX_W-1:0]           map_ru_idx,
  input  logic [NUM_BITS_COLS-1:0]      map_col,
  input  logic                          map_en,
  output logic                          map_err,
  input  logic [COLS*WORD_SIZE-1:0]     systolic_bottom_in,
  input  logic [NUM_RU*WORD_SIZE-1:0]   ru_bottom_in,
  output logic [COLS*WORD_SIZE-1:0]     bottom_out,
  output logic                          out_valid
`ifdef RU_MAP_STATUS_EN
  ,
  output logic [COLS-1:0]               col_remapped,
  output logic [15:0]                   commit_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_SETTLE} state_t;

  state_t                       state, state_nx;
  logic [2:0]                   cnt;
  logic                         tbl_en  [NUM_RU];
  logic [NUM_BITS_COLS-1:0]     tbl_col [NUM_RU];
  logic [RU_IDX_W-1:0]          h_idx;
  logic [NUM_BITS_COLS-1:0]     h_col;
  logic                         h_en;
  logic                         conflict, reject, accept;
  int unsigned                  idx_val, col_val;
  logic [NUM_RU*WORD_SIZE-1:0]  ru_d;
  logic [COLS*WORD_SIZE-1:0]    mux_out;
  logic [COLS-1:0]              hit;

  // Request validation against the current table
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < NUM_RU; i++) begin
      if (tbl_en[i] && (tbl_col[i] == h_col) && (RU_IDX_W'(i) != h_idx))
        conflict = 1'b1;
    end
    idx_val = 32'(h_idx);
    col_val = 32'(h_col);
    // Releases only fail on a bad RU index
    reject = (idx_val >= NUM_RU) || (h_en && ((col_val >= COLS) || conflict));
  end

  always_comb begin
    state_nx = state;
    map_err  = 1'b0;
    accept   = 1'b0;
    case (state)
      S_IDLE:   if (map_valid && map_ready) state_nx = S_COMMIT;
      S_COMMIT: begin
        if (reject) begin
          map_err  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          accept   = 1'b1;
          state_nx = S_SETTLE;
        end
      end
      S_SETTLE: if (cnt == 3'd0) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // map_ready/out_valid are registered from the next state so they are
  // already correct in the first cycle of each state and low out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      map_ready <= 1'b0;
      out_valid <= 1'b0;
      h_idx     <= '0;
      h_col     <= '0;
      h_en      <= 1'b0;
      for (int unsigned i = 0; i < NUM_RU; i++) begin
        tbl_en[i]  <= 1'b0;
        tbl_col[i] <= '0;
      end
    end else begin
      state     <= state_nx;
      map_ready <= (state_nx == S_IDLE);
      out_valid <= (state_nx != S_SETTLE);
      if (state == S_IDLE && map_valid && map_ready) begin
        h_idx <= map_ru_idx;
        h_col <= map_col;
        h_en  <= map_en;
      end
      if (accept) begin
        cnt <= 3'(RU_SKEW);
        for (int unsigned i = 0; i < NUM_RU; i++) begin
          if (RU_IDX_W'(i) == h_idx) begin
            tbl_en[i] <= h_en;
            if (h_en) tbl_col[i] <= h_col;
          end
        end
      end else if (state == S_SETTLE && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  generate
    if (RU_SKEW == 0) begin : g_nodly
      assign ru_d = ru_bottom_in;
    end else begin : g_dly
      logic [NUM_RU*WORD_SIZE-1:0] pipe [RU_SKEW];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned k = 0; k < RU_SKEW; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= ru_bottom_in;
          for (int unsigned k = 1; k < RU_SKEW; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign ru_d = pipe[RU_SKEW-1];
    end
  endgenerate

  // Column steering; the lowest-indexed enabled RU claiming a column wins
  always_comb begin
    mux_out = systolic_bottom_in;
    hit     = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned i = 0; i < NUM_RU; i++) begin
        if (!hit[c] && tbl_en[i] && (tbl_col[i] == NUM_BITS_COLS'(c))) begin
          hit[c] = 1'b1;
          mux_out[c*WORD_SIZE +: WORD_SIZE] = ru_d[i*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bottom_out <= '0;
    else     bottom_out <= mux_out;
  end

`ifdef RU_MAP_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      col_remapped <= '0;
      commit_count <= '0;
    end else begin
      col_remapped <= hit;
      if (accept && commit_count != 16'hFFFF) commit_count <= commit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_recompute_mapper.sv
module tb_recompute_mapper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: COLS=4
  logic        a_valid, a_ready, a_en, a_err, a_ov;
  logic [1:0]  a_idx, a_col;
  logic [63:0] a_sys, a_ru, a_bot;
  // Instance B: COLS=3
  logic        b_valid, b_ready, b_en, b_err, b_ov;
  logic [1:0]  b_idx, b_col;
  logic [47:0] b_sys, b_bot;
  logic [63:0] b_ru;
`ifdef RU_MAP_STATUS_EN
  logic [3:0]  a_rm;
  logic [15:0] a_cc;
  logic [2:0]  b_rm;
  logic [15:0] b_cc;
`endif

  int total = 0;
  int bad   = 0;

  recompute_mapper #(.COLS(4), .WORD_SIZE(16), .NUM_RU(4), .RU_SKEW(2)) u_a (
    .clk(clk), .rst(rst),
    .map_valid(a_valid), .map_ready(a_ready), .map_ru_idx(a_idx),
    .map_col(a_col), .map_en(a_en), .map_err(a_err),
    .systolic_bottom_in(a_sys), .ru_bottom_in(a_ru),
    .bottom_out(a_bot), .out_valid(a_ov)
`ifdef RU_MAP_STATUS_EN
    , .col_remapped(a_rm), .commit_count(a_cc)
`endif
  );

  recompute_mapper #(.COLS(3), .WORD_SIZE(16), .NUM_RU(4), .RU_SKEW(2)) u_b (
    .clk(clk), .rst(rst),
    .map_valid(b_valid), .map_ready(b_ready), .map_ru_idx(b_idx),
    .map_col(b_col), .map_en(b_en), .map_err(b_err),
    .systolic_bottom_in(b_sys), .ru_bottom_in(b_ru),
    .bottom_out(b_bot), .out_valid(b_ov)
`ifdef RU_MAP_STATUS_EN
    , .col_remapped(b_rm), .commit_count(b_cc)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic [1:0] idx, input logic [1:0] col, input logic en);
    a_valid = 1'b1; a_idx = idx; a_col = col; a_en = en;
    tick;
    a_valid = 1'b0;
  endtask

  task automatic req_b(input logic [1:0] idx, input logic [1:0] col, input logic en);
    b_valid = 1'b1; b_idx = idx; b_col = col; b_en = en;
    tick;
    b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_idx = '0; a_col = '0; a_en = 1'b0;
    b_valid = 1'b0; b_idx = '0; b_col = '0; b_en = 1'b0;
    a_sys = 64'h0040_00AA_0020_0010;
    a_ru  = 64'h4444_3333_2222_1111;
    b_sys = 48'h0003_0002_0001;
    b_ru  = 64'h0D0D_0C0C_0B0B_0A0A;

    // Reset held for two edges; this cycle is the first with rst low
    tick; tick;
    rst = 1'b0;
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_ov", a_ov, 1'b0);
    chk("rst_bot", a_bot, 64'h0);
    chk("rst_err", a_err, 1'b0);
    tick;
    chk("post_rst_ready", a_ready, 1'b1);
    chk("post_rst_ov", a_ov, 1'b1);
    chk("post_rst_col2", a_bot[47:32], 16'h00AA);
    chk("post_rst_bot", a_bot, 64'h0040_00AA_0020_0010);
    chk("b_post_rst_bot", b_bot, 48'h0003_0002_0001);
    chk("b_post_rst_ready", b_ready, 1'b1);
`ifdef RU_MAP_STATUS_EN
    chk("post_rst_cc", a_cc, 16'd0);
`endif

    // Basic remap RU1 -> col2
    req_a(2'd1, 2'd2, 1'b1);
    chk("remap_commit_ready", a_ready, 1'b0);
    chk("remap_commit_err", a_err, 1'b0);
    chk("remap_commit_ov", a_ov, 1'b1);
    tick;
    chk("remap_s1_ready", a_ready, 1'b0);
    chk("remap_s1_ov", a_ov, 1'b0);
    tick;
    chk("remap_s2_ov", a_ov, 1'b0);
    chk("remap_s2_bot", a_bot, 64'h0040_2222_0020_0010);
    tick;
    chk("remap_s3_ready", a_ready, 1'b0);
    chk("remap_s3_ov", a_ov, 1'b0);
    tick;
    chk("remap_idle_ready", a_ready, 1'b1);
    chk("remap_idle_ov", a_ov, 1'b1);
    a_ru  = 64'h4444_3333_1234_1111;
    a_sys = 64'h0040_00AA_0020_0055;
    tick;
    a_ru  = 64'h4444_3333_2222_1111;
    chk("sys_lat1_col0", a_bot[15:0], 16'h0055);
    chk("ru_t1_col2", a_bot[47:32], 16'h2222);
    tick;
    chk("ru_t2_col2", a_bot[47:32], 16'h2222);
    tick;
    chk("ru_t3_bot", a_bot, 64'h0040_1234_0020_0055);
    tick;
    chk("ru_t4_col2", a_bot[47:32], 16'h2222);

    // Conflict: RU0 -> col3 accepted, then RU2 -> col3 rejected
    req_a(2'd0, 2'd3, 1'b1);
    chk("c_first_err", a_err, 1'b0);
    tick; tick; tick; tick;
    chk("c_first_ready", a_ready, 1'b1);
    chk("c_first_bot", a_bot, 64'h1111_2222_0020_0055);
    req_a(2'd2, 2'd3, 1'b1);
    chk("c_err", a_err, 1'b1);
    chk("c_err_ov", a_ov, 1'b1);
    chk("c_err_ready", a_ready, 1'b0);
    tick;
    chk("c_err_drop", a_err, 1'b0);
    chk("c_after_ready", a_ready, 1'b1);
    chk("c_after_ov", a_ov, 1'b1);
    tick;
    chk("c_table_kept", a_bot, 64'h1111_2222_0020_0055);
    chk("c_ov_kept", a_ov, 1'b1);

    // Release RU0, then reuse col3 with RU2
    req_a(2'd0, 2'd0, 1'b0);
    chk("rel_err", a_err, 1'b0);
    tick;
    chk("rel_s1_ov", a_ov, 1'b0);
    tick;
    chk("rel_col3_sys", a_bot[63:48], 16'h0040);
    tick; tick;
    chk("rel_idle_ready", a_ready, 1'b1);
    req_a(2'd2, 2'd3, 1'b1);
    chk("reuse_err", a_err, 1'b0);
    tick; tick; tick; tick;
    chk("reuse_bot", a_bot, 64'h3333_2222_0020_0055);
    chk("reuse_ov", a_ov, 1'b1);

    // Move an already enabled RU to another column
    req_a(2'd1, 2'd0, 1'b1);
    chk("move_err", a_err, 1'b0);
    tick; tick; tick; tick;
    chk("move_bot", a_bot, 64'h3333_00AA_0020_2222);
`ifdef RU_MAP_STATUS_EN
    chk("status_cc", a_cc, 16'd5);
    chk("status_rm", a_rm, 4'b1001);
`endif

    // Reset in the second SETTLE cycle
    req_a(2'd0, 2'd1, 1'b1);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_ready", a_ready, 1'b0);
    chk("mid_rst_ov", a_ov, 1'b0);
    chk("mid_rst_bot", a_bot, 64'h0);
    tick;
    chk("mid_post_ready", a_ready, 1'b1);
    chk("mid_post_ov", a_ov, 1'b1);
    chk("mid_post_bot", a_bot, 64'h0040_00AA_0020_0055);
`ifdef RU_MAP_STATUS_EN
    chk("mid_post_cc", a_cc, 16'd0);
    chk("mid_post_rm", a_rm, 4'b0000);
`endif
    tick;
    chk("mid_table_clear", a_bot, 64'h0040_00AA_0020_0055);

    // COLS=3: out-of-range column, then the top valid column
    req_b(2'd0, 2'd3, 1'b1);
    chk("oor_err", b_err, 1'b1);
    chk("oor_ov", b_ov, 1'b1);
    tick;
    chk("oor_err_drop", b_err, 1'b0);
    chk("oor_no_settle_ready", b_ready, 1'b1);
    chk("oor_no_settle_ov", b_ov, 1'b1);
    chk("oor_bot", b_bot, 48'h0003_0002_0001);
    req_b(2'd1, 2'd2, 1'b1);
    chk("b_top_err", b_err, 1'b0);
    tick;
    chk("b_top_settle_ov", b_ov, 1'b0);
    tick; tick; tick;
    chk("b_top_ready", b_ready, 1'b1);
    chk("b_top_bot", b_bot, 48'h0B0B_0002_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/recompute_mapper.md
RECOMPUTE_MAPPER -- requirements
Module: recompute_mapper

Interface
REQ-001 The module SHALL have parameter COLS, default 4, giving the number of systolic columns (minimum 2).
REQ-002 The module SHALL have parameter WORD_SIZE, default 16, giving the data word width.
REQ-003 The module SHALL have parameter NUM_RU, default 4, giving the number of redundant units.
REQ-004 The module SHALL have parameter RU_SKEW, default 2 (range 0..7), giving the cycles by which RU results lead systolic results.
REQ-005 The module SHALL use one clock with a synchronous, active-high reset.
REQ-006 The module SHALL use NUM_BITS_COLS = $clog2(COLS) for column fields.
REQ-007 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- map_valid  in  1  mapping request
- map_ready  out  1  mapper can accept a request
- map_ru_idx  in  $clog2(NUM_RU) (min 1)  RU being remapped
- map_col  in  NUM_BITS_COLS  target column
- map_en  in  1  1 = enable RU on map_col, 0 = release RU
- map_err  out  1  one-cycle pulse when a request is rejected
- systolic_bottom_in  in  COLS*WORD_SIZE  column results, column c at [c*WORD_SIZE +: WORD_SIZE]
- ru_bottom_in  in  NUM_RU*WORD_SIZE  RU results, RU i at [i*WORD_SIZE +: WORD_SIZE]
- bottom_out  out  COLS*WORD_SIZE  repaired column results
- out_valid  out  1  bottom_out uses a settled mapping

Function
REQ-008 The mapping table SHALL hold NUM_RU entries, each {en, col}.
REQ-009 ru_bottom_in SHALL pass through an RU_SKEW-stage delay line, with no delay when RU_SKEW=0.
REQ-010 For each column c, if an enabled entry i has col==c, bottom_out[c] SHALL be the delayed RU i word; otherwise it SHALL be systolic_bottom_in[c]. The lowest i wins, but this tie never occurs because of REQ-014.
REQ-011 bottom_out SHALL be registered, so the systolic path has 1-cycle latency and the RU path has RU_SKEW+1 cycles from ru_bottom_in.
REQ-012 The FSM SHALL have three states:
- IDLE: map_ready=1.
- COMMIT: lasts 1 cycle, map_ready=0.
- SETTLE: lasts RU_SKEW+1 cycles, counted by a down-counter, map_ready=0.
REQ-013 In IDLE, when map_valid&&map_ready, the FSM SHALL capture map_ru_idx, map_col and map_en into holding registers and go to COMMIT. Inputs are ignored when map_ready=0.
REQ-014 In COMMIT, the request SHALL be rejected when map_en=1 and either map_col>=COLS, map_ru_idx>=NUM_RU, or another enabled entry (index != map_ru_idx) already holds map_col. On rejection: map_err=1 for that cycle, table unchanged, next state IDLE.
REQ-015 In COMMIT, a release (map_en=0) SHALL never be rejected, except when map_ru_idx>=NUM_RU, which is rejected.
REQ-016 In COMMIT, an accepted request SHALL update the entry at the clock edge ending COMMIT and move to SETTLE. Re-mapping an already enabled RU to a new column is allowed.
REQ-017 out_valid SHALL be registered and SHALL be 0 during every cycle the FSM is in SETTLE. It SHALL be 1 in all other cycles after the first post-reset cycle.
REQ-018 map_err SHALL be registered-free, driven from the COMMIT decision, and SHALL be 0 outside COMMIT.
REQ-019 The delay line and output register SHALL advance every cycle regardless of FSM state.

Reset
REQ-020 On rst=1 at a clock edge, the following SHALL be cleared:
- all table entries to en=0, col=0;
- delay line and bottom_out to 0;
- out_valid=0, map_ready=0, map_err=0;
- FSM to IDLE, counter to 0.
REQ-021 map_ready SHALL rise in the first cycle after rst deasserts.
REQ-022 A reset during COMMIT or SETTLE SHALL abort the request, and no entry SHALL keep any change from it.

Configuration
REQ-023 When macro RU_MAP_STATUS_EN is defined, the following SHALL be present:
- output col_remapped [COLS], registered and aligned with bottom_out, where bit c=1 when column c is served by an RU;
- output commit_count [15:0], incremented on each accepted request and saturating at 16'hFFFF.
REQ-024 When RU_MAP_STATUS_EN is undefined, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 Reset: hold rst 2 cycles, release -> bottom_out=0, out_valid=0 in the first cycle; then map_ready=1, and with systolic col2=16'h00AA, bottom_out col2=16'h00AA one cycle later.
REQ-026 Basic remap: map RU1->col2 (RU_SKEW=2) -> map_ready low for 1+3 cycles, out_valid low for 3 cycles; RU1 word 16'h1234 driven at T appears on col2 at T+3 while cols 0,1,3 stay systolic.
REQ-027 Conflict: RU0->col3 accepted, then RU2->col3 -> map_err=1 for one cycle, table unchanged, col3 still RU0, out_valid stays 1.
REQ-028 Out-of-range: COLS=3, request map_col=3 with map_en=1 -> map_err pulse, no SETTLE.
REQ-029 Release and reuse: release RU0, then map RU2->col3 -> both accepted; col3 carries RU2 data after settle.
REQ-030 Reset mid-SETTLE: assert rst on the second SETTLE cycle -> all columns systolic, map_ready=1 the cycle after release; with RU_MAP_STATUS_EN, commit_count=0 and col_remapped=0.
